uart_tx_fifo_arbiter: RTL
=========================

// Module: uart_tx_fifo_arbiter
// PURPOSE
//  Shares one synchronous TX FIFO write port among pNumReq byte-stream requesters
//  (command parser, ADC reporter, status/debug) feeding the UART transmitter.
//  Round-robin grant with packet lock: a granted requester owns the FIFO until it
//  writes its last byte, so packets from different sources never interleave.
// PARAMETERS
//  pNumReq        3     number of requesters, 2..8
//  pDataWidth     8     bits per FIFO word
//  pTimeoutCycles 1024  idle cycles before a forced lock release (ARB_TIMEOUT_EN only), >=2
// PORTS
//  iClk            in   1                   system clock, all logic on rising edge
//  iRst            in   1                   asynchronous active-high reset
//  iReqValid       in   pNumReq             requester k has a byte on its data lane
//  iReqData        in   pNumReq*pDataWidth  lane k = bits [k*pDataWidth +: pDataWidth]
//  iReqLast        in   pNumReq             lane k byte is the final byte of its packet
//  oReqReady       out  pNumReq             lane k byte accepted this cycle (one-hot or 0)
//  oFifoWriteEn    out  1                   write strobe to FIFO
//  oFifoWriteData  out  pDataWidth          write data to FIFO
//  iFifoFull       in   1                   FIFO full flag
//  oBusy           out  1                   lock held
//  oGrant          out  $clog2(pNumReq)     index of current/last owner
//  oTimeout        out  1                   1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (async, any state): state IDLE, oGrant=pNumReq-1 (so req 0 has top priority
//    after reset), idle counter 0; oReqReady=0, oFifoWriteEn=0, oFifoWriteData=0,
//    oBusy=0, oTimeout=0.
//  - FSM states: IDLE, LOCK.
//    IDLE: if any iReqValid, pick first set bit scanning oGrant+1, oGrant+2, ... mod
//    pNumReq; register oGrant=winner, go LOCK next edge. No data moves in IDLE.
//    LOCK: transfer = iReqValid[oGrant] & ~iFifoFull. When transfer is 1:
//    oReqReady[oGrant]=1, oFifoWriteEn=1, oFifoWriteData=lane oGrant (combinational
//    from registered grant). Transfer with iReqLast[oGrant]=1 -> IDLE next edge.
//  - Latency: request in IDLE -> first byte written 1 cycle later; 1 bubble cycle in
//    IDLE between packets; throughput 1 byte/cycle inside a packet.
//  - oFifoWriteData = 0 whenever oFifoWriteEn=0.
//  - iFifoFull=1 in LOCK: stall, no ready, no write, lock kept, no data lost.
//  - Non-granted requesters: oReqReady=0; must hold valid/data/last stable until ready.
//  - Owner drops iReqValid mid-packet: lock kept (packet still open).
//  - Single-byte packet (valid & last on first beat): one write, back to IDLE.
//  - Round-robin fairness: with all requesters continuously valid, grants rotate
//    0,1,2,0,... ; a requester waits at most pNumReq-1 packets.
//  - oBusy = (state==LOCK). oGrant holds last owner in IDLE.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in LOCK, idle counter increments each cycle with no transfer
//    and clears on transfer; when it reaches pTimeoutCycles-1 with no transfer, go IDLE
//    next edge, oTimeout=1 for that edge's following cycle, counter cleared. Protects
//    UART from a hung source; partial packet stays in FIFO.
//  ARB_TIMEOUT_EN undefined: no counter, lock held indefinitely, oTimeout tied 0.
// TESTING
//  1 Reset: assert iRst mid-packet (LOCK, owner 1) -> all outputs 0 same cycle, oGrant=2;
//    after release req 1 valid alone -> granted next cycle.
//  2 Req0 sends 0xA1,0xA2,0xA3(last) while req1 valid with 0x55(last) -> FIFO gets
//    A1,A2,A3,55 in order; bubble cycle between A3 and 55; never interleaved.
//  3 All three valid, 1-byte packets, continuous -> grant order 0,1,2,0,1,2.
//  4 Req2 in LOCK, iFifoFull=1 for 5 cycles mid-packet -> no writes, oReqReady=0,
//    oBusy=1; on full=0 next byte written first cycle.
//  5 ARB_TIMEOUT_EN, pTimeoutCycles=16: req0 sends 0x10 (not last) then drops valid ->
//    after 16 idle cycles oTimeout pulses once, oBusy=0, waiting req1 granted next.
//  6 Without ARB_TIMEOUT_EN, same stimulus for 2000 cycles -> oBusy stays 1, oTimeout 0.

Source files
------------

// File: rtl/uart_tx_fifo_arbiter.sv
// ============================================================================
// Module   : uart_tx_fifo_arbiter
// Brief    : Round-robin, packet-locked arbiter sharing one TX FIFO write port.
//            Optional forced lock release on idle owner: define ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_arbiter #(
  parameter int pNumReq        = 3,
  parameter int pDataWidth     = 8,
  parameter int pTimeoutCycles = 1024
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [pNumReq-1:0]            iReqValid,
  input  logic [pNumReq*pDataWidth-1:0] iReqData,
  input  logic [pNumReq-1:0]            iReqLast,
  output logic [pNumReq-1:0]            oReqReady,
  output logic                          oFifoWriteEn,
  output logic [pDataWidth-1:0]         oFifoWriteData,
  input  logic                          iFifoFull,
  output logic                          oBusy,
  output logic [$clog2(pNumReq)-1:0]    oGrant,
  output logic                          oTimeout
);

  localparam int GW = $clog2(pNumReq);
  localparam logic [GW-1:0] C_GRANT_RST = GW'(pNumReq - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           winner_w;
  logic                    found_w;
  logic                    xfer_w;
  logic                    expire_w;
  logic [pDataWidth-1:0]   lane_w [pNumReq];

  generate
    for (genvar k = 0; k < pNumReq; k++) begin : g_lane
      assign lane_w[k]    = iReqData[k*pDataWidth +: pDataWidth];
      assign oReqReady[k] = xfer_w && (grant_q == GW'(k));
    end
  endgenerate

  // Scan starts one past the last owner, so the last owner has lowest priority.
  always_comb begin : p_arb
    logic [GW-1:0] cand;
    cand     = '0;
    winner_w = grant_q;
    found_w  = 1'b0;
    for (int i = 1; i <= pNumReq; i++) begin
      cand = GW'((int'(grant_q) + i) % pNumReq);
      if (!found_w && iReqValid[cand]) begin
        found_w  = 1'b1;
        winner_w = cand;
      end
    end
  end

  assign xfer_w = (state_q == ST_LOCK) && iReqValid[grant_q] && !iFifoFull;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (pTimeoutCycles > 2) ? $clog2(pTimeoutCycles) : 1;
  localparam logic [CW-1:0] C_IDLE_LAST = CW'(pTimeoutCycles - 1);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_q;

  assign expire_w = (state_q == ST_LOCK) && !xfer_w && (idle_cnt_q == C_IDLE_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q == ST_LOCK) begin
      idle_cnt_d = (xfer_w || expire_w) ? '0 : idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= expire_w;
    end
  end

  assign oTimeout = timeout_q;
`else
  assign expire_w = 1'b0;
  assign oTimeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (found_w) begin
          grant_d = winner_w;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // The lock only opens on the owner's last byte (or a forced release).
        if ((xfer_w && iReqLast[grant_q]) || expire_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      grant_q <= C_GRANT_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign oFifoWriteEn   = xfer_w;
  assign oFifoWriteData = xfer_w ? lane_w[grant_q] : '0;
  assign oBusy          = (state_q == ST_LOCK);
  assign oGrant         = grant_q;

endmodule

`default_nettype wire
